simon_kexp_stream: RTL and testbench
====================================

# simon_kexp_stream

Streaming, multi-mode Simon key expander: accepts a master key and mode selector, then emits round keys one per cycle on a ready/valid stream in round order. It does not hold a full expanded-key array; it keeps only an m-word sliding window. It sits between the key-load interface and a Simon round datapath that consumes round keys as it encrypts. It covers all ten Simon block/key configurations, adds back-pressure, abort and illegal-mode reporting, and keeps register cost independent of round count.

## Interface
- SIMON_MAX_WORD_WIDTH, 64: widest supported word n; modes with n above this are illegal.
- SIMON_KEY_WIDTH, 256: key port width; must be ≥ m·n of every legal mode.
- ck  in  1  clock, rising edge.
- nrst  in  1  reset; one clock; reset is asynchronous and active-low.
- mode  in  4  configuration select (see Operation).
- key  in  SIMON_KEY_WIDTH  master key; word j = key[j·n +: n], word 0 is k0.
- k_valid  in  1  key/mode offered.
- k_ready  out  1  high only in IDLE.
- k_err  out  1  one-cycle pulse on an illegal-mode request.
- abort  in  1  terminate the current expansion.
- rk  out  SIMON_MAX_WORD_WIDTH  round key, zero-extended above bit n-1.
- rk_idx  out  7  round index of rk, 0..T-1.
- rk_last  out  1  rk_idx == T-1.
- rk_valid  out  1  rk, rk_idx and rk_last are valid.
- rk_ready  in  1  consumer accepts the beat.

## Operation
Each mode is given as n/m/T/z:
- 0: 32/64 = 16/4/32/z0
- 1: 48/72 = 24/3/36/z0
- 2: 48/96 = 24/4/36/z1
- 3: 64/96 = 32/3/42/z2
- 4: 64/128 = 32/4/44/z3
- 5: 96/96 = 48/2/52/z2
- 6: 96/144 = 48/3/54/z3
- 7: 128/128 = 64/2/68/z2
- 8: 128/192 = 64/3/69/z3
- 9: 128/256 = 64/4/72/z4

Modes 10–15 are illegal, as is any mode with n > SIMON_MAX_WORD_WIDTH.

z constants:
- z_j are the published 62-symbol sequences, stored with bit i = symbol i (leftmost symbol first).
- z0 = 11111010001001010110000111001101111101000100101011000011100110
- z1 = 10001110111110010011000010110101000111011111001001100001011010
- z2 = 10101111011100000011010010011000101000010001111110010110110011
- z3 = 11011011101011000110010111100000010010001010011100110100001111
- z4 = 11010001111001101011011000100000010111000011001010010011101111

States:
- IDLE:
  - k_ready=1, rk_valid=0.
  - On k_valid with a legal mode: latch the config, set window w[j] = key word j for j<m, set idx=0 and zidx=0, go to STREAM.
  - On k_valid with an illegal mode: pulse k_err for one cycle, stay in IDLE, leave all registers unchanged.
- STREAM:
  - rk_valid = !abort; rk = w[0]; rk_idx = idx.
  - On a beat (rk_valid && rk_ready):
    - w[j] ← w[j+1].
    - w[m-1] ← new word computed from the current window, using z bit zidx.
    - idx++; zidx wraps from 61 to 0 (no divider).
    - If rk_last, go to IDLE.
  - abort=1: go to IDLE; this cycle is not a beat, and rk_ready is ignored.

New word arithmetic (all in n bits, rotations within n bits):
- t = w[m-1] ror 3.
- If m==4: t ^= w[1].
- t ^= t ror 1.
- new = ~w[0] ^ t ^ z[zidx] ^ 3.

Other rules:
- Key bits at m·n and above are ignored.
- rk bits at n and above are always 0.
- The window is m·SIMON_MAX_WORD_WIDTH wide; lanes j ≥ m are don't-care.

## Timing
- Reset values: state IDLE, k_ready=1, k_err=0, rk_valid=0, rk=0, rk_idx=0, rk_last=0, window=0.
- Key acceptance takes one cycle. The first beat (idx 0) is valid in the next cycle.
- Throughput is one round key per cycle with rk_ready held high. Accept at cycle c gives beats at c+1..c+T, and k_ready high at c+T+1.
- Under stall (rk_valid && !rk_ready), rk, rk_idx and rk_last hold stable.
- rk_valid never drops without a beat, except on abort or reset.
- abort in IDLE has no effect. After an abort, the next key can be accepted in the following cycle.
- nrst asserted mid-stream forces IDLE immediately (asynchronously). No partial beat survives.
- k_err is registered: it goes high the cycle after the illegal request.

## Test plan
- Mode 0, key 0x1918_1110_0908_0100, rk_ready=1: rk = 0x0100, 0x0908, 0x1110, 0x1918, 0x71C3 at idx 0..4. All 32 beats match the software model; rk_last only at idx 31; k_ready returns 33 cycles after accept.
- Modes 7 and 9, random keys: 68 and 72 beats match the model. The mode 9 check covers z wrap at idx 62..71.
- Mode 4 with random rk_ready (50%): rk, rk_idx and rk_last are stable across stalls; the sequence is identical to the unstalled run; upper 32 bits of rk are 0.
- mode=12 with k_valid: k_err high for exactly 1 cycle, k_ready stays 1, no rk_valid. A following legal request is accepted normally.
- Mode 8, abort at idx 10: rk_valid is 0 that cycle, IDLE next cycle. A new mode 1 key then produces a correct 36-beat stream from idx 0.
- nrst pulsed at idx 20 in mode 5: all outputs at reset values immediately; a new key after release streams correctly.

Source files
------------

// File: rtl/simon_kexp_stream.sv
// Simon key expander for all ten block/key modes; one cycle to accept a key, then one round key per cycle.
// Round-key outputs hold while rk_valid && !rk_ready; abort drops the stream and returns to idle.
module simon_kexp_stream #(
  parameter int SIMON_MAX_WORD_WIDTH = 64,
  parameter int SIMON_KEY_WIDTH      = 256
) (
  input  logic                            ck,
  input  logic                            nrst,
  input  logic [3:0]                      mode,
  input  logic [SIMON_KEY_WIDTH-1:0]      key,
  input  logic                            k_valid,
  output logic                            k_ready,
  output logic                            k_err,
  input  logic                            abort,
  output logic [SIMON_MAX_WORD_WIDTH-1:0] rk,
  output logic [6:0]                      rk_idx,
  output logic                            rk_last,
  output logic                            rk_valid,
  input  logic                            rk_ready
);
  localparam int W = SIMON_MAX_WORD_WIDTH;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_STREAM = 1'b1;

  typedef struct packed {
    logic [6:0] n;
    logic [2:0] m;
    logic [6:0] t;
    logic [2:0] zsel;
  } cfg_t;

  function automatic logic [61:0] rev62(input logic [61:0] s);
    logic [61:0] r;
    for (int i = 0; i < 62; i++) r[i] = s[61-i];
    return r;
  endfunction

  // Sequences are written leftmost symbol first, then flipped so bit i is symbol i.
  localparam logic [61:0] Z0 = rev62(62'b11111010001001010110000111001101111101000100101011000011100110);
  localparam logic [61:0] Z1 = rev62(62'b10001110111110010011000010110101000111011111001001100001011010);
  localparam logic [61:0] Z2 = rev62(62'b10101111011100000011010010011000101000010001111110010110110011);
  localparam logic [61:0] Z3 = rev62(62'b11011011101011000110010111100000010010001010011100110100001111);
  localparam logic [61:0] Z4 = rev62(62'b11010001111001101011011000100000010111000011001010010011101111);

  function automatic logic decode(input logic [3:0] md, output cfg_t c);
    logic ok;
    ok = 1'b1;
    c  = '0;
    case (md)
      4'd0:    c = '{n: 7'd16, m: 3'd4, t: 7'd32, zsel: 3'd0};
      4'd1:    c = '{n: 7'd24, m: 3'd3, t: 7'd36, zsel: 3'd0};
      4'd2:    c = '{n: 7'd24, m: 3'd4, t: 7'd36, zsel: 3'd1};
      4'd3:    c = '{n: 7'd32, m: 3'd3, t: 7'd42, zsel: 3'd2};
      4'd4:    c = '{n: 7'd32, m: 3'd4, t: 7'd44, zsel: 3'd3};
      4'd5:    c = '{n: 7'd48, m: 3'd2, t: 7'd52, zsel: 3'd2};
      4'd6:    c = '{n: 7'd48, m: 3'd3, t: 7'd54, zsel: 3'd3};
      4'd7:    c = '{n: 7'd64, m: 3'd2, t: 7'd68, zsel: 3'd2};
      4'd8:    c = '{n: 7'd64, m: 3'd3, t: 7'd69, zsel: 3'd3};
      4'd9:    c = '{n: 7'd64, m: 3'd4, t: 7'd72, zsel: 3'd4};
      default: ok = 1'b0;
    endcase
    if (int'(c.n) > W) ok = 1'b0;
    return ok;
  endfunction

  function automatic logic [W-1:0] lane_mask(input logic [6:0] n);
    return (int'(n) >= W) ? '1 : ((W'(1) << n) - W'(1));
  endfunction

  function automatic logic [W-1:0] ror_n(input logic [W-1:0] x, input logic [6:0] s,
                                         input logic [6:0] n);
    logic [W-1:0] xm;
    xm = x & lane_mask(n);
    return ((xm >> s) | (xm << (n - s))) & lane_mask(n);
  endfunction

  logic [0:0]   state;
  cfg_t         cfg_r;
  cfg_t         in_cfg;
  logic         in_legal;
  logic [W-1:0] w       [4];
  logic [W-1:0] w_load  [4];
  logic [W-1:0] w_shift [4];
  logic [6:0]   idx;
  logic [5:0]   zidx;
  logic [61:0]  zrow;
  logic         z_bit;
  logic [1:0]   top_lane;
  logic [W-1:0] t_rot;
  logic [W-1:0] t_mix;
  logic [W-1:0] new_word;
  logic         streaming;
  logic         last;

  always_comb begin
    in_legal = decode(mode, in_cfg);
    for (int j = 0; j < 4; j++) begin
      w_load[j] = '0;
      if (j < int'(in_cfg.m))
        w_load[j] = W'(key >> (j * int'(in_cfg.n))) & lane_mask(in_cfg.n);
    end
  end

  // Next key word from the sliding window; it lands in lane m-1 as the window shifts down.
  always_comb begin
    case (cfg_r.zsel)
      3'd1:    zrow = Z1;
      3'd2:    zrow = Z2;
      3'd3:    zrow = Z3;
      3'd4:    zrow = Z4;
      default: zrow = Z0;
    endcase
    z_bit    = zrow[zidx];
    top_lane = 2'(cfg_r.m - 3'd1);
    t_rot    = ror_n(w[top_lane], 7'd3, cfg_r.n);
    if (cfg_r.m == 3'd4) t_rot = t_rot ^ w[1];
    t_mix    = t_rot ^ ror_n(t_rot, 7'd1, cfg_r.n);
    new_word = (~w[0] ^ t_mix ^ W'(z_bit) ^ W'(3)) & lane_mask(cfg_r.n);
    w_shift[0] = w[1];
    w_shift[1] = w[2];
    w_shift[2] = w[3];
    w_shift[3] = '0;
    w_shift[top_lane] = new_word;
  end

  assign streaming = (state == ST_STREAM);
  assign last      = (idx == cfg_r.t - 7'd1);
  assign k_ready   = !streaming;
  assign rk_valid  = streaming && !abort;
  assign rk        = streaming ? w[0] : '0;
  assign rk_idx    = streaming ? idx : '0;
  assign rk_last   = streaming && last;

  always_ff @(posedge ck or negedge nrst) begin
    if (!nrst) begin
      state <= ST_IDLE;
      cfg_r <= '0;
      idx   <= '0;
      zidx  <= '0;
      k_err <= 1'b0;
      for (int j = 0; j < 4; j++) w[j] <= '0;
    end else begin
      k_err <= 1'b0;
      if (!streaming) begin
        if (k_valid && in_legal) begin
          cfg_r <= in_cfg;
          for (int j = 0; j < 4; j++) w[j] <= w_load[j];
          idx   <= '0;
          zidx  <= '0;
          state <= ST_STREAM;
        end else if (k_valid) begin
          k_err <= 1'b1;
        end
      end else if (abort) begin
        state <= ST_IDLE;
      end else if (rk_ready) begin
        for (int j = 0; j < 4; j++) w[j] <= w_shift[j];
        idx  <= idx + 7'd1;
        zidx <= (zidx == 6'd61) ? 6'd0 : zidx + 6'd1;
        if (last) state <= ST_IDLE;
      end
    end
  end
endmodule

// File: tb/tb_simon_kexp_stream.sv
// Directed bench for simon_kexp_stream: expected round keys come from an indexed full-schedule
// model of the Simon key expansion, plus hand-computed first words for the Simon32/64 key.
module tb_simon_kexp_stream;
  logic         ck = 1'b0;
  logic         nrst;
  logic [3:0]   mode;
  logic [255:0] key;
  logic         k_valid;
  logic         k_ready;
  logic         k_err;
  logic         abort;
  logic [63:0]  rk;
  logic [6:0]   rk_idx;
  logic         rk_last;
  logic         rk_valid;
  logic         rk_ready;

  int checks   = 0;
  int failures = 0;

  int N_TAB [10] = '{16, 24, 24, 32, 32, 48, 48, 64, 64, 64};
  int M_TAB [10] = '{4, 3, 4, 3, 4, 2, 3, 2, 3, 4};
  int T_TAB [10] = '{32, 36, 36, 42, 44, 52, 54, 68, 69, 72};
  int Z_TAB [10] = '{0, 0, 1, 2, 3, 2, 3, 2, 3, 4};
  logic [61:0] ZS [5] = '{
    62'b11111010001001010110000111001101111101000100101011000011100110,
    62'b10001110111110010011000010110101000111011111001001100001011010,
    62'b10101111011100000011010010011000101000010001111110010110110011,
    62'b11011011101011000110010111100000010010001010011100110100001111,
    62'b11010001111001101011011000100000010111000011001010010011101111};
  logic [63:0] HAND [5] = '{64'h0100, 64'h0908, 64'h1110, 64'h1918, 64'h71C3};
  logic [63:0] exp_rk [0:71];

  always #5 ck = ~ck;

  simon_kexp_stream #(.SIMON_MAX_WORD_WIDTH(64), .SIMON_KEY_WIDTH(256)) dut (
    .ck(ck), .nrst(nrst), .mode(mode), .key(key), .k_valid(k_valid), .k_ready(k_ready),
    .k_err(k_err), .abort(abort), .rk(rk), .rk_idx(rk_idx), .rk_last(rk_last),
    .rk_valid(rk_valid), .rk_ready(rk_ready));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge ck);
    #1;
  endtask

  function automatic logic [63:0] rotr(input logic [63:0] x, input int s, input int n);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[i] = x[(i + s) % n];
    return r;
  endfunction

  task automatic build_model(input int md, input logic [255:0] k);
    int n, m, t;
    logic [63:0] mask, tmp;
    logic [61:0] zr;
    n  = N_TAB[md];
    m  = M_TAB[md];
    t  = T_TAB[md];
    zr = ZS[Z_TAB[md]];
    mask = (n == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << n) - 64'd1);
    for (int i = 0; i < m; i++) exp_rk[i] = 64'(k >> (i * n)) & mask;
    for (int i = m; i < t; i++) begin
      tmp = rotr(exp_rk[i-1], 3, n);
      if (m == 4) tmp = tmp ^ exp_rk[i-3];
      tmp = tmp ^ rotr(tmp, 1, n);
      exp_rk[i] = (~exp_rk[i-m] ^ tmp ^ 64'(zr[61 - ((i - m) % 62)]) ^ 64'd3) & mask;
    end
  endtask

  task automatic beat_check(input string tag, input int got, input int t);
    check({tag, ".rk"}, rk, exp_rk[got]);
    check({tag, ".idx"}, 64'(rk_idx), 64'(got));
    check({tag, ".last"}, 64'(rk_last), 64'(got == t - 1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".k_ready"}, 64'(k_ready), 64'd1);
    check({tag, ".k_err"}, 64'(k_err), 64'd0);
    check({tag, ".rk_valid"}, 64'(rk_valid), 64'd0);
    check({tag, ".rk"}, rk, 64'd0);
    check({tag, ".rk_idx"}, 64'(rk_idx), 64'd0);
    check({tag, ".rk_last"}, 64'(rk_last), 64'd0);
  endtask

  task automatic run_stream(input string tag, input int md, input logic [255:0] k,
                            input bit rand_rdy, input bit hand);
    int t, got, cyc;
    t = T_TAB[md];
    got = 0;
    cyc = 0;
    build_model(md, k);
    mode = 4'(md);
    key = k;
    k_valid = 1'b1;
    step();
    k_valid = 1'b0;
    mode = 4'd0;
    while (got < t && cyc < 4 * t + 20) begin
      rk_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (cyc == 0) check({tag, ".k_ready_busy"}, 64'(k_ready), 64'd0);
      if (!rk_valid) check({tag, ".valid"}, 64'(rk_valid), 64'd1);
      else begin
        beat_check(tag, got, t);
        if (N_TAB[md] < 64) check({tag, ".upper"}, rk >> N_TAB[md], 64'd0);
        if (hand && got < 5) check({tag, ".hand"}, rk, HAND[got]);
        if (rk_ready) got++;
      end
      cyc++;
      step();
    end
    check({tag, ".beats"}, 64'(got), 64'(t));
    if (!rand_rdy) check({tag, ".cycles"}, 64'(cyc), 64'(t));
    rk_ready = 1'b1;
    #1;
    check({tag, ".k_ready_end"}, 64'(k_ready), 64'd1);
    check({tag, ".idle_valid"}, 64'(rk_valid), 64'd0);
  endtask

  initial begin
    logic [255:0] k4, kr;
    nrst = 1'b0; mode = 4'd0; key = '0; k_valid = 1'b0; abort = 1'b0; rk_ready = 1'b0;
    #12;
    check_reset_outputs("reset");
    step();
    nrst = 1'b1;
    step();

    // abort while idle is ignored
    abort = 1'b1;
    step();
    abort = 1'b0;
    #1;
    check("idle_abort.k_ready", 64'(k_ready), 64'd1);
    check("idle_abort.rk_valid", 64'(rk_valid), 64'd0);

    run_stream("m0", 0, 256'h1918_1110_0908_0100, 1'b0, 1'b1);
    run_stream("m7", 7, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
    run_stream("m9", 9, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
    k4 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    run_stream("m4", 4, k4, 1'b0, 1'b0);
    run_stream("m4_stall", 4, k4, 1'b1, 1'b0);

    // illegal mode request
    mode = 4'd12;
    k_valid = 1'b1;
    step();
    k_valid = 1'b0;
    #1;
    check("illegal.k_err", 64'(k_err), 64'd1);
    check("illegal.k_ready", 64'(k_ready), 64'd1);
    check("illegal.rk_valid", 64'(rk_valid), 64'd0);
    step();
    #1;
    check("illegal.k_err_drop", 64'(k_err), 64'd0);
    check("illegal.rk_valid2", 64'(rk_valid), 64'd0);
    run_stream("m2", 2, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);

    // abort at idx 10 in mode 8
    kr = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    build_model(8, kr);
    mode = 4'd8; key = kr; k_valid = 1'b1; rk_ready = 1'b1;
    step();
    k_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("m8.valid", 64'(rk_valid), 64'd1);
      beat_check("m8", i, 69);
      step();
    end
    abort = 1'b1;
    #1;
    check("abort.rk_valid", 64'(rk_valid), 64'd0);
    check("abort.rk_idx", 64'(rk_idx), 64'd10);
    step();
    abort = 1'b0;
    #1;
    check("abort.k_ready", 64'(k_ready), 64'd1);
    check("abort.idle_valid", 64'(rk_valid), 64'd0);
    run_stream("m1", 1, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);

    // asynchronous reset at idx 20 in mode 5
    kr = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    build_model(5, kr);
    mode = 4'd5; key = kr; k_valid = 1'b1; rk_ready = 1'b1;
    step();
    k_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      check("m5.valid", 64'(rk_valid), 64'd1);
      beat_check("m5", i, 52);
      step();
    end
    nrst = 1'b0;
    #1;
    check_reset_outputs("nrst_mid");
    step();
    nrst = 1'b1;
    step();
    run_stream("m5_after", 5, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
